// File: rtl/adder_arbiter_if.sv
// Request, adder and result bundle for the shared-adder arbiter.
// master is the arbiter side; slave is the requester/adder side.
interface adder_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DIM       = 2,
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = WIDTH + 4,
  parameter int ID_WIDTH  = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*DIM*WIDTH-1:0] req_vector;
  logic [NREQ-1:0]           req_ready;
  logic [DIM*WIDTH-1:0]      adder_vector;
  logic                      adder_start;
  logic                      adder_finished;
  logic [RES_WIDTH-1:0]      adder_sum;
  logic                      res_valid;
  logic [ID_WIDTH-1:0]       res_id;
  logic [RES_WIDTH-1:0]      res_sum;
  logic                      res_error;
  logic                      busy;

  modport master (
    input  req_valid,
    input  req_vector,
    input  adder_finished,
    input  adder_sum,
    output req_ready,
    output adder_vector,
    output adder_start,
    output res_valid,
    output res_id,
    output res_sum,
    output res_error,
    output busy
  );

  modport slave (
    output req_valid,
    output req_vector,
    output adder_finished,
    output adder_sum,
    input  req_ready,
    input  adder_vector,
    input  adder_start,
    input  res_valid,
    input  res_id,
    input  res_sum,
    input  res_error,
    input  busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one parallelAdder between NREQ requesters,
// with a watchdog that aborts an operation whose adder never finishes.
module adder_arbiter #(
  parameter int DIM       = 2,
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = WIDTH + 4,
  parameter int NREQ      = 4,
  parameter int ID_WIDTH  = 2,
  parameter int TIMEOUT   = 64
) (
  input logic            Clock,
  input logic            Reset,
  adder_arbiter_if.master bus
);

  localparam int VW = DIM * WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [ID_WIDTH-1:0]  ptr;
  logic [ID_WIDTH-1:0]  grant;
  logic [ID_WIDTH-1:0]  win_id;
  logic                 found;
  logic [CW-1:0]        cnt;
  logic [VW-1:0]        vec_q;
  logic [RES_WIDTH-1:0] sum_q;
  logic                 err_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 tmo;
  logic [VW-1:0]        slices [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slices[g] = bus.req_vector[g*VW +: VW];
  end

  // Upward search from ptr, wrapping at NREQ (not at 2**ID_WIDTH).
  always_comb begin
    logic [ID_WIDTH:0] s;
    win_id = '0;
    found  = 1'b0;
    s      = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, ptr} + (ID_WIDTH+1)'(i);
      if (s >= (ID_WIDTH+1)'(NREQ))
        s = s - (ID_WIDTH+1)'(NREQ);
      if (!found && bus.req_valid[s[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        win_id = s[ID_WIDTH-1:0];
      end
    end
  end

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_n         = state;
    bus.req_ready   = '0;
    bus.adder_start = 1'b0;
    bus.res_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !Reset) begin
          bus.req_ready = NREQ'(1) << win_id;
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        bus.adder_start = 1'b1;
        state_n         = WAIT;
      end
      WAIT: begin
        if (bus.adder_finished || tmo)
          state_n = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
      vec_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
      id_q  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (found) begin
            vec_q <= slices[win_id];
            grant <= win_id;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // A finish on the timeout cycle still counts as success.
          if (bus.adder_finished) begin
            sum_q <= bus.adder_sum;
            err_q <= 1'b0;
            id_q  <= grant;
          end else if (tmo) begin
            sum_q <= '0;
            err_q <= 1'b1;
            id_q  <= grant;
          end
        end
        DONE: begin
          if (grant == ID_WIDTH'(NREQ - 1))
            ptr <= '0;
          else
            ptr <= grant + ID_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.adder_vector = vec_q;
  assign bus.res_sum      = sum_q;
  assign bus.res_error    = err_q;
  assign bus.res_id       = id_q;
  assign bus.busy         = (state != IDLE);

endmodule
